multdiv_iter: RTL and testbench
===============================

Name: multdiv_iter

Overview:
- Iterative signed multiply/divide unit in the execute stage, beside the ALU and barrel shifters; shares operand buses A/B with them.
- The result is muxed into the execute-to-memory latch.
- Multiply is radix-2 Booth and divide is restoring, each using one shared WIDTH-bit adder/subtractor and shift registers, one step per cycle.
- The pipeline stalls on busy and consumes the result on data_resultRDY.

Parameters:
WIDTH, 32, operand/result width; the counter width is clog2(WIDTH)+1.

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
data_operandA  input  WIDTH  multiplicand / dividend (two's complement)
data_operandB  input  WIDTH  multiplier / divisor (two's complement)
ctrl_MULT  input  1  one-cycle start pulse for multiply; operands sampled this cycle
ctrl_DIV  input  1  one-cycle start pulse for divide; operands sampled this cycle
data_result  output  WIDTH  low WIDTH bits of product, or quotient
data_exception  output  1  multiply overflow, divide by zero, or divide overflow
data_resultRDY  output  1  one-cycle pulse: result and exception valid
busy  output  1  operation in progress

Behaviour:
- Interface: one clock and one reset; reset is synchronous and active-high.
- Reset: state IDLE, counter 0. data_result=0, data_exception=0, data_resultRDY=0, busy=0.
- States: IDLE, MUL, DIV, DONE.
- Start: the edge on which ctrl_MULT or ctrl_DIV is high loads the operands and enters MUL or DIV, with counter=0. busy=1 from the next cycle.
- Simultaneous ctrl_MULT and ctrl_DIV: multiply wins.
- MUL step (per cycle): examine {Q[0],Q-1}.
  - 01: add M to the upper half.
  - 10: subtract M from the upper half.
  - Then arithmetic-shift right the 2*WIDTH+1 accumulator by 1.
- DIV:
  - Operate on absolute values, one restoring step per cycle: shift left, trial subtract, restore if negative, quotient bit = not negative.
  - Quotient sign = signA xor signB; truncate toward zero. The remainder is discarded.
- Completion: after WIDTH steps (counter reaches WIDTH-1), go to DONE.
  - DONE lasts one cycle: data_resultRDY=1, busy=0, then IDLE.
  - Fixed latency: start at edge 0, RDY high in cycle WIDTH+1 (cycle 33 for WIDTH=32) for every op, including exceptions.
- data_result and data_exception update only on entry to DONE and hold until the next DONE or reset.
- Multiply exception: set when the 2*WIDTH-bit product is not the sign-extension of its low WIDTH bits. The result is still the low WIDTH bits.
- Divide by zero: exception=1, result=0 (fixed latency kept).
- Divide overflow (most-negative / -1): exception=1, result=most-negative (0x80000000).
- Start while busy (MUL/DIV/DONE): abort the current op with no RDY for it, reload the new operands, and restart the latency count.
- Reset mid-operation: on the reset edge, return to the IDLE state with all outputs at reset values. No RDY pulse.
- Operands must not be re-sampled after start; inputs may change freely while busy.

Decomposition:
- Shared package:
  - state encodings (IDLE/MUL/DIV/DONE, 2 bits)
  - Booth pair constants
  - the most-negative constant, derived from WIDTH
- One sub-module: addsub_nbit (WIDTH-bit adder with subtract control, carry/overflow out), instantiated once and time-shared between MUL and DIV.
- Sign fix-up (negate) reuses the same adder in the DONE transition, or a second instance of addsub_nbit; no other sub-modules.

Test Plan:
- Multiply: reset, then ctrl_MULT with A=7, B=-3.
  - RDY high exactly at cycle 33, result=0xFFFFFFEB, exception=0, busy high cycles 1-32.
- Multiply overflow: A=0x00010000, B=0x00010000.
  - result=0x00000000, exception=1. Also A=0x80000000, B=-1 gives result 0x80000000, exception=1.
- Divide: A=-7, B=2.
  - result=0xFFFFFFFD (-3), exception=0.
  - A=100, B=0 gives result 0, exception=1, both at cycle 33.
  - A=0x80000000, B=-1 gives result 0x80000000, exception=1.
- Restart and priority:
  - ctrl_DIV A=20, B=4 at cycle 0, then ctrl_MULT A=6, B=5 at cycle 10.
  - No RDY at cycle 33; RDY at cycle 43 with result=30.
  - Both ctrl high together performs the multiply.
- Reset mid-operation: assert reset at cycle 15 of a multiply.
  - Outputs go to 0 and busy=0 after the edge, no RDY ever appears.
  - A new op started afterwards completes normally with correct latency.

Source files
------------

// File: rtl/multdiv_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM state
// encoding, Booth recoding pairs and a helper that builds the most-negative
// two's complement value for any operand width up to MAX_WIDTH.
package multdiv_iter_pkg;

  // Operation sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Booth pair {Q[0], Q-1}: 01 adds the multiplicand, 10 subtracts it,
  // 00/11 leave the upper half alone before the shift.
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  // Widest operand the helper below can describe.
  localparam int unsigned MAX_WIDTH = 64;

  // Most-negative value of a 'width'-bit two's complement number, returned
  // right-aligned in a MAX_WIDTH container; callers slice off their width.
  function automatic logic [MAX_WIDTH-1:0] most_neg(input int unsigned width);
    most_neg = {{(MAX_WIDTH-1){1'b0}}, 1'b1} << (width - 1);
  endfunction

endpackage

// File: rtl/addsub_nbit.sv
// WIDTH-bit adder/subtractor: sum = a + b (sub=0) or a - b (sub=1).
// Latency: combinational. Backpressure: none (pure datapath).
// Ports: a, b operands; sub selects subtract; sum result; cout carry out
// (for subtract, 1 means no borrow, i.e. a >= b unsigned); ovf signed overflow.
module addsub_nbit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;

  // Subtract as a + ~b + 1: invert b and feed sub in as the carry.
  assign b_eff = b ^ {WIDTH{sub}};
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

  // Signed overflow: both addends share a sign the result does not.
  assign ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/multdiv_iter.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring), one step per cycle.
// Latency: start edge 0, data_resultRDY pulses in cycle WIDTH+1 for every op, exceptions included.
// Backpressure: none; pipeline stalls on busy, a new start while busy aborts and restarts.
// Ports: clock/reset (sync, active-high); data_operandA/B operands sampled on the
// start edge; ctrl_MULT/ctrl_DIV one-cycle start pulses (multiply wins when both);
// data_result/data_exception held from DONE entry; data_resultRDY one-cycle valid; busy.
module multdiv_iter
  import multdiv_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int                      CW            = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]           LAST_STEP     = CW'(WIDTH - 1);
  localparam logic [MAX_WIDTH-1:0]    MOST_NEG_FULL = most_neg(WIDTH);
  localparam logic [WIDTH-1:0]        MOST_NEG      = MOST_NEG_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0]        ALL_ONES      = '1;

  // Datapath registers, shared between the two algorithms:
  //   MUL: acc_hi = upper product half P, acc_lo = multiplier Q, q_m1 = Q-1,
  //        mcand = multiplicand M.
  //   DIV: acc_hi = partial remainder R, acc_lo = |dividend| shifting out
  //        while quotient bits shift in, mcand = signed divisor.
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] mcand;
  logic             q_m1;
  logic             q_neg;
  logic             div_zero;
  logic             div_ovf;

  logic             start;
  logic             last;
  logic [1:0]       booth;
  logic [WIDTH-1:0] rem_shift;

  assign start     = ctrl_MULT | ctrl_DIV;
  assign last      = (cnt == LAST_STEP);
  assign booth     = {acc_lo[0], q_m1};
  // Remainder shifted left with the next dividend bit. The top bit of R is
  // always zero here because R < |divisor| <= 2^(WIDTH-1).
  assign rem_shift = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};

  // ---------------------------------------------------------------------
  // Step adder, time-shared between Booth add/sub and the trial subtract.
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_sub;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             add_ovf;

  always_comb begin
    add_a   = acc_hi;
    add_b   = mcand;
    add_sub = 1'b0;
    if (state == ST_MUL) begin
      add_sub = (booth == BOOTH_SUB);
    end else if (state == ST_DIV) begin
      // Trial R - |B| without forming |B|: add B when B is negative,
      // subtract it otherwise. The carry out is then set exactly when the
      // unsigned difference is non-negative, even for B = most-negative.
      add_a   = rem_shift;
      add_sub = ~mcand[WIDTH-1];
    end
  end

  addsub_nbit #(.WIDTH(WIDTH)) u_step (
    .a    (add_a),
    .b    (add_b),
    .sub  (add_sub),
    .sum  (add_sum),
    .cout (add_cout),
    .ovf  (add_ovf)
  );

  // ---------------------------------------------------------------------
  // Booth step: optional add/sub into P, then arithmetic shift of {P,Q,Q-1}.
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] p_sel;
  logic             p_sign;
  logic [WIDTH-1:0] mul_hi_nxt;
  logic [WIDTH-1:0] mul_lo_nxt;
  logic             mul_exc;

  always_comb begin
    if ((booth == BOOTH_ADD) || (booth == BOOTH_SUB)) begin
      // P +/- M can overflow WIDTH bits (e.g. M = most-negative); the true
      // sign is the sum MSB corrected by overflow, and the shift brings the
      // value back into range, so shifting in the true sign stays exact.
      p_sel  = add_sum;
      p_sign = add_sum[WIDTH-1] ^ add_ovf;
    end else begin
      p_sel  = acc_hi;
      p_sign = acc_hi[WIDTH-1];
    end
    mul_hi_nxt = {p_sign, p_sel[WIDTH-1:1]};
    mul_lo_nxt = {p_sel[0], acc_lo[WIDTH-1:1]};
  end

  // Overflow when the full product is not the sign extension of its low half.
  assign mul_exc = (mul_hi_nxt != {WIDTH{mul_lo_nxt[WIDTH-1]}});

  // ---------------------------------------------------------------------
  // Restoring divide step: keep the difference only if it did not go negative.
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] div_hi_nxt;
  logic [WIDTH-1:0] div_lo_nxt;

  assign div_hi_nxt = add_cout ? add_sum : rem_shift;
  assign div_lo_nxt = {acc_lo[WIDTH-2:0], add_cout};

  // ---------------------------------------------------------------------
  // Negator: |dividend| on the start edge, signed quotient on the final
  // divide edge. A start on the final edge aborts that divide, so the start
  // operand takes the negator without losing anything.
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] fix_in;
  logic [WIDTH-1:0] fix_sum;
  logic             fix_cout_unused;
  logic             fix_ovf_unused;

  assign fix_in = start ? data_operandA : div_lo_nxt;

  addsub_nbit #(.WIDTH(WIDTH)) u_fix (
    .a    ({WIDTH{1'b0}}),
    .b    (fix_in),
    .sub  (1'b1),
    .sum  (fix_sum),
    .cout (fix_cout_unused),
    .ovf  (fix_ovf_unused)
  );

  // ---------------------------------------------------------------------
  // Sequencer and registered outputs.
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      acc_hi         <= '0;
      acc_lo         <= '0;
      mcand          <= '0;
      q_m1           <= 1'b0;
      q_neg          <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else if (start) begin
      // A start in any state (re)loads and restarts the latency count; an
      // aborted op never pulses RDY. Result/exception keep their old values.
      cnt            <= '0;
      acc_hi         <= '0;
      q_m1           <= 1'b0;
      busy           <= 1'b1;
      data_resultRDY <= 1'b0;
      q_neg          <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      div_zero       <= (data_operandB == '0);
      div_ovf        <= (data_operandA == MOST_NEG) && (data_operandB == ALL_ONES);
      if (ctrl_MULT) begin
        state  <= ST_MUL;
        mcand  <= data_operandA;
        acc_lo <= data_operandB;
      end else begin
        state  <= ST_DIV;
        mcand  <= data_operandB;
        acc_lo <= data_operandA[WIDTH-1] ? fix_sum : data_operandA;
      end
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        ST_MUL: begin
          acc_hi <= mul_hi_nxt;
          acc_lo <= mul_lo_nxt;
          q_m1   <= acc_lo[0];
          cnt    <= cnt + CW'(1);
          if (last) begin
            state          <= ST_DONE;
            busy           <= 1'b0;
            data_resultRDY <= 1'b1;
            data_result    <= mul_lo_nxt;
            data_exception <= mul_exc;
          end
        end
        ST_DIV: begin
          acc_hi <= div_hi_nxt;
          acc_lo <= div_lo_nxt;
          cnt    <= cnt + CW'(1);
          if (last) begin
            state          <= ST_DONE;
            busy           <= 1'b0;
            data_resultRDY <= 1'b1;
            data_exception <= div_zero | div_ovf;
            // Exceptional divides still run all steps so latency is fixed;
            // their result is substituted here.
            if (div_zero) begin
              data_result <= '0;
            end else if (div_ovf) begin
              data_result <= MOST_NEG;
            end else begin
              data_result <= q_neg ? fix_sum : div_lo_nxt;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_iter.sv
// Self-checking bench for multdiv_iter: directed literal cases plus random
// ops, all checked every cycle against a countdown/arithmetic model.
module tb_multdiv_iter;

  localparam int W   = 32;
  localparam int LAT = 33;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  data_operandA = '0;
  logic [W-1:0]  data_operandB = '0;
  logic          ctrl_MULT = 1'b0;
  logic          ctrl_DIV = 1'b0;
  logic [W-1:0]  data_result;
  logic          data_exception;
  logic          data_resultRDY;
  logic          busy;

  int n_cmp  = 0;
  int n_fail = 0;

  multdiv_iter #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: {exception, result}.
  function automatic logic [32:0] ref_op(input bit mul, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q;
    logic [31:0] lo;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (mul) begin
      p  = sa * sb;
      lo = p[31:0];
      return {(p != longint'($signed(lo))), lo};
    end
    if (b == 32'd0) return {1'b1, 32'd0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    q = sa / sb;
    return {1'b0, q[31:0]};
  endfunction

  // Model: a pending op completes 32 edges after its start edge; a new start
  // replaces it, reset drops it. Outputs checked on every falling edge.
  longint      edge_cnt = 0;
  longint      due = 0;
  bit          pend = 0;
  logic [32:0] pend_val = '0;
  logic [31:0] held_res = '0;
  logic        held_exc = 1'b0;
  bit          exp_busy = 0;
  bit          exp_rdy = 0;

  initial begin
    forever begin
      @(posedge clock);
      edge_cnt++;
      if (reset) begin
        pend = 0; exp_busy = 0; exp_rdy = 0; held_res = '0; held_exc = 1'b0;
      end else begin
        exp_rdy = 0;
        if (ctrl_MULT || ctrl_DIV) begin
          pend_val = ref_op(ctrl_MULT, data_operandA, data_operandB);
          pend     = 1;
          due      = edge_cnt + (LAT - 1);
          exp_busy = 1;
        end else if (pend && edge_cnt == due) begin
          held_exc = pend_val[32];
          held_res = pend_val[31:0];
          exp_rdy  = 1;
          exp_busy = 0;
          pend     = 0;
        end
      end
      @(negedge clock);
      chk("busy", busy, exp_busy);
      chk("rdy", data_resultRDY, exp_rdy);
      chk("result", data_result, held_res);
      chk("exception", data_exception, held_exc);
    end
  end

  // Drive a one-cycle start; returns at the falling edge of cycle 1.
  // Operands are scrambled right after so any re-sampling shows up.
  task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
    @(negedge clock);
    ctrl_MULT = 0; ctrl_DIV = 0; data_operandA = $urandom; data_operandB = $urandom;
  endtask

  task automatic wait_rdy(output int lat);
    lat = 1;
    while (data_resultRDY !== 1'b1 && lat < 60) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic run_op(input string name, input bit m, input bit d, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic ee);
    int lat;
    start_op(m, d, a, b);
    wait_rdy(lat);
    chk({name, "_latency"}, lat, LAT);
    chk({name, "_result"}, data_result, er);
    chk({name, "_exc"}, data_exception, ee);
  endtask

  logic [31:0] corners [8] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                               32'h7FFF_FFFF, 32'h2, 32'hFFFF_FFFE, 32'h0001_0000};

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: v = corners[$urandom_range(0, 7)];
      1: begin
        v = $urandom_range(0, 60);
        if ($urandom_range(0, 1) == 1) v = -v;
      end
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int lat;
    int rdy_seen;
    bit m;
    bit d;

    repeat (2) @(negedge clock);
    chk("reset_result", data_result, 32'h0);
    chk("reset_exc", data_exception, 1'b0);
    chk("reset_rdy", data_resultRDY, 1'b0);
    chk("reset_busy", busy, 1'b0);
    reset = 1'b0;

    run_op("mul_7x-3",     1, 0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    run_op("mul_ovf_2p32", 1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
    run_op("mul_min_x-1",  1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run_op("div_-7/2",     0, 1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0);
    run_op("div_by_zero",  0, 1, 32'd100,       32'd0,         32'h0000_0000, 1'b1);
    run_op("div_min/-1",   0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run_op("div_min/3",    0, 1, 32'h8000_0000, 32'd3,         32'hD555_5556, 1'b0);

    // Restart: divide at edge 0, multiply at edge 10, RDY only at cycle 43.
    start_op(0, 1, 32'd20, 32'd4);
    rdy_seen = 0;
    repeat (8) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) rdy_seen++;
    end
    start_op(1, 0, 32'd6, 32'd5);
    wait_rdy(lat);
    chk("restart_no_early_rdy", rdy_seen, 0);
    chk("restart_latency", lat, LAT);
    chk("restart_result", data_result, 32'd30);

    // Both starts together: multiply wins (divide would give 1).
    run_op("both_ctrl", 1, 1, 32'd6, 32'd5, 32'd30, 1'b0);

    // Reset in the middle of a multiply.
    start_op(1, 0, 32'd123, 32'd456);
    repeat (13) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_result", data_result, 32'h0);
    chk("midrst_exc", data_exception, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    rdy_seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) rdy_seen++;
    end
    chk("midrst_no_rdy", rdy_seen, 0);
    run_op("after_rst_mul", 1, 0, 32'hFFFF_FFFB, 32'hFFFF_FFF7, 32'd45, 1'b0);

    // Random ops, occasionally cut short by the next start.
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0:       begin m = 1; d = 1; end
        1, 2, 3: begin m = 1; d = 0; end
        default: begin m = 0; d = 1; end
      endcase
      start_op(m, d, pick_operand(), pick_operand());
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(0, 34)) @(negedge clock);
      end else begin
        wait_rdy(lat);
        chk("rand_latency", lat, LAT);
      end
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    repeat (40) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
